// File: rtl/store_buffer_lsu_if.sv
// store_buffer_lsu_if: bundles the MEM-stage load/store handshake, the status
// outputs and the single-port data-memory connection of the store-buffer LSU.
// slave  = the LSU side, master = the pipeline / memory environment side.
interface store_buffer_lsu_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_st_valid;
    logic          w_st_ready;
    logic [31:0]   w_st_addr_32;
    logic [31:0]   w_st_data_32;
    logic          w_st_byte_op;
    logic          w_ld_valid;
    logic [31:0]   w_ld_addr_32;
    logic          w_ld_byte_op;
    logic          w_ld_signed;
    logic          w_ld_hazard;
    logic [31:0]   w_ld_data_32;
    logic          w_misaligned;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_mem_addr_32;
    logic [31:0]   w_mem_data_32;
    logic          w_mem_en;
    logic          w_mem_write_op;
    logic          w_mem_byte_op;
    logic [31:0]   w_mem_rdata_32;
    logic [7:0]    w_mem_rdata_8;

    modport slave (
        input  w_st_valid, w_st_addr_32, w_st_data_32, w_st_byte_op,
        input  w_ld_valid, w_ld_addr_32, w_ld_byte_op, w_ld_signed,
        input  w_mem_rdata_32, w_mem_rdata_8,
        output w_st_ready, w_ld_hazard, w_ld_data_32, w_misaligned, w_empty, w_count,
        output w_mem_addr_32, w_mem_data_32, w_mem_en, w_mem_write_op, w_mem_byte_op
    );

    modport master (
        output w_st_valid, w_st_addr_32, w_st_data_32, w_st_byte_op,
        output w_ld_valid, w_ld_addr_32, w_ld_byte_op, w_ld_signed,
        output w_mem_rdata_32, w_mem_rdata_8,
        input  w_st_ready, w_ld_hazard, w_ld_data_32, w_misaligned, w_empty, w_count,
        input  w_mem_addr_32, w_mem_data_32, w_mem_en, w_mem_write_op, w_mem_byte_op
    );
endinterface

// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: load/store unit with a DEPTH-entry posted-store FIFO in
// front of a single-port data memory. Loads own the port; stores drain one per
// cycle whenever the port is free. A load that word-matches a pending (or
// concurrent) store stalls until that store has drained.
// Optional feature macro: STORE_FWD_EN -- forwards data from the youngest
// matching store for the word/word, word/byte and exact byte/byte cases.
module store_buffer_lsu #(
    parameter int DEPTH = 4
) (
    input logic               clock,
    input logic               reset_n,
    store_buffer_lsu_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    // Sign/zero extension of a loaded or forwarded byte
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // FIFO storage and control state
    logic [31:0]      ent_addr_q [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] ent_byte_q;
    logic [DEPTH-1:0] ent_vld_q;
    logic [DEPTH-1:0] ent_vld_d;
    ptr_t             rd_ptr_q;
    ptr_t             rd_ptr_d;
    ptr_t             wr_ptr_q;
    ptr_t             wr_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             misal_q;
    logic             misal_d;

    // Request decode
    logic        st_misal_s;
    logic        ld_misal_s;
    logic        q_hit_s;
    logic        st_hit_s;
    logic        any_hit_s;
    logic        hazard_s;
    logic        fwd_take_s;
    logic [31:0] fwd_val_s;
    logic        ld_grant_s;
    logic        push_s;
    logic        pop_s;
    logic        st_ready_s;

    // Port / result drive
    logic [31:0] mem_addr_s;
    logic [31:0] mem_data_s;
    logic        mem_en_s;
    logic        mem_wr_s;
    logic        mem_byte_s;
    logic [31:0] ld_data_s;

    assign st_ready_s = (count_q != FULL_CNT);

    // Alignment checks and word-address matches against queued and concurrent stores
    always_comb begin
        st_misal_s = bus.w_st_valid & ~bus.w_st_byte_op & (bus.w_st_addr_32[1:0] != 2'd0);
        ld_misal_s = bus.w_ld_valid & ~bus.w_ld_byte_op & (bus.w_ld_addr_32[1:0] != 2'd0);
        q_hit_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q_hit_s = q_hit_s | (ent_vld_q[i] & (ent_addr_q[i][31:2] == bus.w_ld_addr_32[31:2]));
        end
        st_hit_s  = bus.w_st_valid & (bus.w_st_addr_32[31:2] == bus.w_ld_addr_32[31:2]);
        any_hit_s = bus.w_ld_valid & ~ld_misal_s & (q_hit_s | st_hit_s);
    end

`ifdef STORE_FWD_EN
    logic        fwd_found_s;
    logic        fwd_bad_s;
    logic        fwd_byte_s;
    logic        fwd_ok_s;
    logic [31:0] fwd_addr_s;
    logic [31:0] fwd_data_s;
    logic [7:0]  fwd_lane_s;
    ptr_t        scan_idx_s;

    // Pick the youngest matching store (concurrent store is youngest) and decide if it can forward
    always_comb begin
        fwd_found_s = 1'b0;
        fwd_bad_s   = 1'b0;
        fwd_byte_s  = 1'b0;
        fwd_addr_s  = 32'h0000_0000;
        fwd_data_s  = 32'h0000_0000;
        scan_idx_s  = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx_s = rd_ptr_q + ptr_t'(k);
            if ((CW'(k) < count_q) &&
                (ent_addr_q[scan_idx_s][31:2] == bus.w_ld_addr_32[31:2])) begin
                fwd_found_s = 1'b1;
                fwd_bad_s   = 1'b0;
                fwd_byte_s  = ent_byte_q[scan_idx_s];
                fwd_addr_s  = ent_addr_q[scan_idx_s];
                fwd_data_s  = ent_data_q[scan_idx_s];
            end else begin
                fwd_found_s = fwd_found_s;
            end
        end
        if (st_hit_s) begin
            // a misaligned concurrent word store is never enqueued, so it cannot source data
            fwd_found_s = 1'b1;
            fwd_bad_s   = st_misal_s;
            fwd_byte_s  = bus.w_st_byte_op;
            fwd_addr_s  = bus.w_st_addr_32;
            fwd_data_s  = bus.w_st_data_32;
        end else begin
            fwd_found_s = fwd_found_s;
        end

        case (bus.w_ld_addr_32[1:0])
            2'd0:    fwd_lane_s = fwd_data_s[31:24];
            2'd1:    fwd_lane_s = fwd_data_s[23:16];
            2'd2:    fwd_lane_s = fwd_data_s[15:8];
            default: fwd_lane_s = fwd_data_s[7:0];
        endcase

        if (!fwd_found_s || fwd_bad_s) begin
            fwd_ok_s = 1'b0;
        end else if (!fwd_byte_s) begin
            fwd_ok_s = 1'b1;
        end else if (bus.w_ld_byte_op && (fwd_addr_s == bus.w_ld_addr_32)) begin
            fwd_ok_s = 1'b1;
        end else begin
            fwd_ok_s = 1'b0;
        end

        if (!bus.w_ld_byte_op) begin
            fwd_val_s = fwd_data_s;
        end else if (!fwd_byte_s) begin
            fwd_val_s = ext_byte(fwd_lane_s, bus.w_ld_signed);
        end else begin
            fwd_val_s = ext_byte(fwd_data_s[7:0], bus.w_ld_signed);
        end

        fwd_take_s = any_hit_s & fwd_ok_s;
        hazard_s   = any_hit_s & ~fwd_ok_s;
    end
`else
    // Without forwarding every word match stalls the load
    always_comb begin
        fwd_take_s = 1'b0;
        fwd_val_s  = 32'h0000_0000;
        hazard_s   = any_hit_s;
    end
`endif

    // Memory port arbitration: granted load first, else drain the FIFO head
    always_comb begin
        mem_addr_s = 32'h0000_0000;
        mem_data_s = 32'h0000_0000;
        mem_en_s   = 1'b0;
        mem_wr_s   = 1'b0;
        mem_byte_s = 1'b0;
        pop_s      = 1'b0;
        ld_data_s  = 32'h0000_0000;
        ld_grant_s = bus.w_ld_valid & ~ld_misal_s & ~hazard_s & ~fwd_take_s;
        if (ld_grant_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = bus.w_ld_addr_32;
            mem_byte_s = bus.w_ld_byte_op;
            if (bus.w_ld_byte_op) begin
                ld_data_s = ext_byte(bus.w_mem_rdata_8, bus.w_ld_signed);
            end else begin
                ld_data_s = bus.w_mem_rdata_32;
            end
        end else if ((count_q != {CW{1'b0}}) && reset_n) begin
            // no drain while reset is asserted: pending stores are being discarded
            mem_en_s   = 1'b1;
            mem_wr_s   = 1'b1;
            mem_addr_s = ent_addr_q[rd_ptr_q];
            mem_data_s = ent_data_q[rd_ptr_q];
            mem_byte_s = ent_byte_q[rd_ptr_q];
            pop_s      = 1'b1;
            ld_data_s  = fwd_take_s ? fwd_val_s : 32'h0000_0000;
        end else begin
            ld_data_s  = fwd_take_s ? fwd_val_s : 32'h0000_0000;
        end
    end

    // FIFO next-state: push/pop, pointer wrap, occupancy and misalignment pulse
    always_comb begin
        push_s    = bus.w_st_valid & st_ready_s & ~st_misal_s;
        rd_ptr_d  = pop_s  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        wr_ptr_d  = push_s ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        count_d   = count_q + CW'(push_s) - CW'(pop_s);
        ent_vld_d = ent_vld_q;
        if (pop_s) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
        end else begin
            ent_vld_d = ent_vld_d;
        end
        if (push_s) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
        end else begin
            ent_vld_d = ent_vld_d;
        end
        misal_d = st_misal_s | ld_misal_s;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ent_vld_q  <= '0;
            ent_byte_q <= '0;
            misal_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= 32'h0000_0000;
                ent_data_q[i] <= 32'h0000_0000;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ent_vld_q <= ent_vld_d;
            misal_q   <= misal_d;
            if (push_s) begin
                ent_addr_q[wr_ptr_q] <= bus.w_st_addr_32;
                ent_data_q[wr_ptr_q] <= bus.w_st_data_32;
                ent_byte_q[wr_ptr_q] <= bus.w_st_byte_op;
            end
        end
    end

    assign bus.w_st_ready     = st_ready_s;
    assign bus.w_ld_hazard    = hazard_s;
    assign bus.w_ld_data_32   = ld_data_s;
    assign bus.w_misaligned   = misal_q;
    assign bus.w_empty        = (count_q == {CW{1'b0}});
    assign bus.w_count        = count_q;
    assign bus.w_mem_addr_32  = mem_addr_s;
    assign bus.w_mem_data_32  = mem_data_s;
    assign bus.w_mem_en       = mem_en_s;
    assign bus.w_mem_write_op = mem_wr_s;
    assign bus.w_mem_byte_op  = mem_byte_s;
endmodule

// File: doc/store_buffer_lsu.md
Name: store_buffer_lsu

Overview:
- Load/store unit between the MEM pipeline stage and the single-port data memory; the data memory has a combinational read, a write on clock posedge, and byte/word ops.
- Stores are posted into a DEPTH-entry FIFO and drained to memory one per cycle when the port is free. Loads take priority on the port and return extended data the same cycle.
- A load that hits a pending store raises a hazard (stall) until that store has drained.
- Addresses are CPU addresses (0x8002_0000 region), passed to memory unchanged; memory does the translation.

Parameters:
- DEPTH, 4, store FIFO entries; power of 2, >= 2.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  synchronous active-low reset.
- w_st_valid  in  1  store request from MEM stage.
- w_st_ready  out  1  FIFO can accept a store; = !full.
- w_st_addr_32  in  32  store address.
- w_st_data_32  in  32  store data; byte stores use [7:0].
- w_st_byte_op  in  1  1 = byte store, 0 = word store.
- w_ld_valid  in  1  load request from MEM stage.
- w_ld_addr_32  in  32  load address.
- w_ld_byte_op  in  1  1 = byte load.
- w_ld_signed  in  1  byte load sign-extends when 1, zero-extends when 0.
- w_ld_hazard  out  1  load cannot complete this cycle; pipeline stalls.
- w_ld_data_32  out  32  load result, valid when w_ld_valid && !w_ld_hazard.
- w_misaligned  out  1  registered one-cycle pulse: a word op with addr[1:0] != 0 was rejected.
- w_empty  out  1  FIFO empty.
- w_count  out  $clog2(DEPTH)+1  occupied entries.
- w_mem_addr_32  out  32  to memory w_addr_32.
- w_mem_data_32  out  32  to memory w_data_in_32.
- w_mem_en  out  1  to memory w_en.
- w_mem_write_op  out  1  to memory w_write_op.
- w_mem_byte_op  out  1  to memory w_byte_op.
- w_mem_rdata_32  in  32  from memory w_data_out_32; big-endian, addr byte in [31:24].
- w_mem_rdata_8  in  8  from memory w_data_out_8.

Behaviour:
- Reset (reset_n = 0 at posedge):
  - count = 0, read/write pointers = 0, entries invalid.
  - w_misaligned = 0.
  - Combinational outputs then give w_empty = 1, w_st_ready = 1, w_mem_en = 0, w_ld_hazard = 0.
  - Reset mid-drain discards all pending stores.
- Enqueue:
  - w_st_valid && w_st_ready && aligned enqueues {addr, data, byte_op} at the posedge.
  - A word store with addr[1:0] != 0 is not enqueued; w_misaligned = 1 for the next cycle.
- Load word match: entry word address addr[31:2] equals w_ld_addr_32[31:2].
- Hazard:
  - w_ld_hazard = w_ld_valid && (word match against any valid entry OR against a concurrent w_st_valid store).
  - A misaligned word load also sets hazard = 0, data = 0, and pulses w_misaligned.
- Port arbitration, combinational, each cycle:
  1. Load granted (w_ld_valid && !w_ld_hazard && aligned): w_mem_en = 1, write_op = 0, w_mem_addr = w_ld_addr_32, w_mem_byte_op = w_ld_byte_op.
  2. Else if count > 0: drain head. w_mem_en = 1, write_op = 1, addr/data/byte_op from the head entry; head pops at the posedge. Latency is 1 cycle from enqueue to earliest memory write.
  3. Else: w_mem_en = 0, write_op = 0; addr/data are don't-care and driven 0.
- Load data:
  - Word load: w_ld_data_32 = w_mem_rdata_32.
  - Byte load: {24{w_ld_signed & rdata_8[7]}, rdata_8}.
  - Output is 0 when no load is granted.
- Count and pointers:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Full (count == DEPTH): w_st_ready = 0 even if a pop occurs that cycle.
- Simultaneous w_st_valid and w_ld_valid is legal: the store enqueues, and the load hazards if it word-matches that store.
- A hazard always resolves: loads are suppressed while hazard = 1, so drain proceeds.

Optional Feature:
- Macro STORE_FWD_EN.
- Defined: on a word match, the youngest matching entry (concurrent store counts as youngest) is examined:
  - Word store, word load, same addr: forward data, no hazard.
  - Word store, byte load: forward lane addr[1:0] (0 -> [31:24] ... 3 -> [7:0]), then extend per w_ld_signed.
  - Byte store, byte load, identical full addr: forward [7:0], extended.
  - Any other match: hazard = 1 as in the base behaviour.
  - A forwarded load does not use the memory port; drain proceeds that cycle.
- Undefined: any match -> hazard; no forwarding logic.

Test Plan:
- Reset, then SW 0x80020000 <- 0xDEADBEEF with no loads -> w_count = 1 after the edge; next cycle w_mem_en = 1, write_op = 1, data 0xDEADBEEF; count = 0 after.
- 5 back-to-back SWs with ld_valid held to an unrelated address (DEPTH = 4) -> ready = 0 after the 4th; loads keep the port; 5th accepted one cycle after the load is released.
- SW 0x80020010 <- 0x11223344 queued, then LB signed at 0x80020010 -> hazard = 1 until drained, then data 0x00000011. With STORE_FWD_EN: no hazard, data 0x00000011.
- SB 0x80020003 <- 0x80, drained, then LB signed / unsigned at 0x80020003 -> 0xFFFFFF80 / 0x00000080.
- SW to 0x80020002 -> not enqueued, w_misaligned high exactly one cycle, count unchanged.
- 3 stores queued, reset_n = 0 for one cycle -> w_count = 0, w_empty = 1, w_mem_en = 0; no further writes.
